// File: rtl/fft_frame_ctrl.sv
// Frame controller for the in-place FFT core: loads one bit-reversed frame, starts the core,
// waits out its run time, then drains the bins through a 2-entry back-pressured output FIFO.
module fft_frame_ctrl #(
    parameter int LOGN       = 12,
    parameter int FW         = 32,
    parameter int CW         = 64,
    parameter int RUN_CYCLES = 36872,
    parameter int TW         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [FW-1:0]   s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [CW-1:0]   m_data,
    output logic            m_last,
    output logic            fft_rst,
    output logic            fft_sig,
    output logic            fft_we,
    output logic            fft_rev,
    output logic [LOGN-1:0] fft_addr,
    output logic [CW-1:0]   fft_din,
    input  logic [CW-1:0]   fft_dout
);

    typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

    localparam logic [LOGN-1:0] LAST_IDX = '1;
    localparam logic [TW-1:0]   RUN_LAST = TW'(RUN_CYCLES - 1);

    state_t          state, state_nxt;
    logic [LOGN-1:0] cnt;
    logic [TW-1:0]   timer;
    logic            rd_done;
    logic            rd_pend;
    logic            rd_pend_last;
    logic            rst_meta;
    logic            tail_v;
    logic            tail_last;
    logic [CW-1:0]   tail_data;
    logic            accept;
    logic            pop;
    logic            issue;
    logic            frame_done;
    logic [2:0]      in_use;

    assign s_ready    = (state == LOAD) && !fft_rst;
    assign accept     = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign frame_done = (state == DRAIN) && pop && m_last;

    // fft_addr is the read pointer during DRAIN; the core returns its word one clock later,
    // so only one read is ever in flight. Slots freed by a same-cycle pop count as free.
    assign in_use = 3'(m_valid) + 3'(tail_v) + 3'(rd_pend) - 3'(pop);
    assign issue  = (state == DRAIN) && !rd_done && (in_use < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b1;
            fft_rst  <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            fft_rst  <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && cnt == LAST_IDX) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (timer == RUN_LAST) state_nxt = DRAIN;
            DRAIN:   if (frame_done) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            timer        <= '0;
            rd_done      <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            fft_sig      <= 1'b0;
            fft_we       <= 1'b0;
            fft_rev      <= 1'b0;
            fft_addr     <= '0;
            fft_din      <= '0;
        end else begin
            fft_we       <= accept;
            fft_sig      <= (state == START);
            rd_pend      <= issue;
            rd_pend_last <= issue && (fft_addr == LAST_IDX);
            if (accept) begin
                fft_addr <= cnt;
                fft_din  <= {s_data, {FW{1'b0}}};
                fft_rev  <= 1'b1;
                cnt      <= cnt + 1'b1;
            end
            case (state)
                START: begin
                    timer    <= '0;
                    fft_addr <= '0;
                    fft_rev  <= 1'b0;
                end
                RUN: timer <= timer + 1'b1;
                DRAIN: begin
                    if (issue) begin
                        fft_addr <= fft_addr + 1'b1;
                        rd_done  <= (fft_addr == LAST_IDX);
                    end
                    if (frame_done) begin
                        cnt      <= '0;
                        timer    <= '0;
                        rd_done  <= 1'b0;
                        fft_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head register drives m_* directly; tail only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            tail_v    <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else if (pop) begin
            if (tail_v) begin
                m_data <= tail_data;
                m_last <= tail_last;
                if (rd_pend) begin
                    tail_data <= fft_dout;
                    tail_last <= rd_pend_last;
                end else begin
                    tail_v <= 1'b0;
                end
            end else if (rd_pend) begin
                m_data <= fft_dout;
                m_last <= rd_pend_last;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (rd_pend) begin
            if (!m_valid) begin
                m_valid <= 1'b1;
                m_data  <= fft_dout;
                m_last  <= rd_pend_last;
            end else begin
                tail_v    <= 1'b1;
                tail_data <= fft_dout;
                tail_last <= rd_pend_last;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a memory-only stand-in for the FFT core
// (bit-reversed writes, busy window after start, one-clock registered reads).
module tb_fft_frame_ctrl;

    localparam int LOGN       = 4;
    localparam int N          = 1 << LOGN;
    localparam int FW         = 32;
    localparam int CW         = 64;
    localparam int RUN_CYCLES = 40;
    localparam int TW         = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [FW-1:0]   s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [CW-1:0]   m_data;
    logic            m_last;
    logic            fft_rst;
    logic            fft_sig;
    logic            fft_we;
    logic            fft_rev;
    logic [LOGN-1:0] fft_addr;
    logic [CW-1:0]   fft_din;
    logic [CW-1:0]   fft_dout = '0;

    fft_frame_ctrl #(
        .LOGN(LOGN), .FW(FW), .CW(CW), .RUN_CYCLES(RUN_CYCLES), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .fft_rst(fft_rst), .fft_sig(fft_sig), .fft_we(fft_we), .fft_rev(fft_rev),
        .fft_addr(fft_addr), .fft_din(fft_din), .fft_dout(fft_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [CW-1:0] data; logic last;} bin_t;
    typedef struct packed {logic [LOGN-1:0] addr; logic [FW-1:0] data;} wr_t;

    bin_t exp_q[$];
    wr_t  wr_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int r_duty = 100;
    bit full_rate = 1'b0;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) if (v[b]) r |= 1 << (LOGN - 1 - b);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Core stand-in: stored words read back unchanged, but garbage while the transform runs.
    logic [CW-1:0] mem [N];
    int busy = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fft_rst)      busy <= 0;
        else if (fft_sig) busy <= RUN_CYCLES - 1;
        else if (busy > 0) busy <= busy - 1;
        if (fft_we) mem[fft_rev ? bitrev(int'(fft_addr)) : int'(fft_addr)] <= fft_din;
        fft_dout <= (busy != 0) ? 64'hDEAD_BEEF_DEAD_BEEF : mem[fft_addr];
    end

    initial forever begin
        @(negedge clk);
        m_ready = ($urandom_range(99) < r_duty);
    end

    int   frames_done = 0;
    int   sig_count = 0;
    int   last_pop_edge = 0;
    int   first_acc_edge = 0;
    int   wr_cnt = 0;
    int   sig_cyc = 0;
    int   first_pop = 0;
    int   pop_n = 0;
    bit   prev_sig = 0;
    bit   running = 0;
    bit   first_pending = 0;
    bit   busy_phase = 0;
    bit   after_last = 0;
    bit   prev_stall = 0;
    logic [CW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        bin_t e;
        wr_t  w;
        #2;
        if (!rst) begin
            wr_cnt = 0; prev_sig = 0; running = 0; first_pending = 0;
            busy_phase = 0; after_last = 0; prev_stall = 0; pop_n = 0;
        end else begin
            if (fft_we) begin
                if (wr_q.size() == 0) chk("spurious_write", 64'(fft_we), 64'(0));
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 64'(fft_addr), 64'(w.addr));
                    chk("wr_data", fft_din, {w.data, 32'h0});
                    chk("wr_rev", 64'(fft_rev), 64'(1));
                end
                chk("we_while_running", 64'(running), 64'(0));
                wr_cnt++;
                if (wr_cnt == N) busy_phase = 1;
            end
            if (fft_sig) begin
                chk("sig_width", 64'(prev_sig), 64'(0));
                if (!prev_sig) begin
                    chk("writes_before_sig", 64'(wr_cnt), 64'(N));
                    wr_cnt = 0; sig_cyc = cyc; running = 1; first_pending = 1;
                    sig_count++;
                end
            end
            prev_sig = fft_sig;
            if (m_valid && first_pending) begin
                chk("run_latency", 64'(cyc - sig_cyc), 64'(RUN_CYCLES + 2));
                first_pending = 0; running = 0;
            end
            if (busy_phase) chk("s_ready_busy", 64'(s_ready), 64'(0));
            if (after_last) begin
                chk("ready_after_last", 64'(s_ready), 64'(1));
                after_last = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'(1));
                chk("stall_data", m_data, prev_data);
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (pop_n == 0) first_pop = cyc;
                pop_n++;
                if (exp_q.size() == 0) chk("unexpected_bin", m_data, 64'(0) - 1);
                else begin
                    e = exp_q.pop_front();
                    chk("bin_data", m_data, e.data);
                    chk("bin_last", 64'(m_last), 64'(e.last));
                end
                if (m_last) begin
                    if (full_rate) chk("burst_len", 64'(cyc - first_pop), 64'(N - 1));
                    chk("bins_per_frame", 64'(pop_n), 64'(N));
                    pop_n = 0;
                    frames_done++;
                    last_pop_edge = cyc + 1;
                    after_last = 1;
                    busy_phase = 0;
                end
            end
        end
    end

    task automatic load_frame(input int duty, input bit dc);
        int i = 0;
        int budget = 2000;
        logic [FW-1:0] samp [N];
        while (i < N && budget > 0) begin
            @(negedge clk);
            budget--;
            s_data  = dc ? 32'h3F80_0000 : $urandom();
            s_valid = ($urandom_range(99) < duty);
            if (s_valid && s_ready) begin
                if (i == 0) first_acc_edge = cyc + 1;
                wr_q.push_back('{addr: LOGN'(i), data: s_data});
                samp[i] = s_data;
                i++;
            end
        end
        if (i < N) begin
            tests++; fails++;
            $display("FAIL load_timeout: accepted %0d of %0d samples", i, N);
        end else begin
            for (int k = 0; k < N; k++)
                exp_q.push_back('{data: {samp[bitrev(k)], 32'h0}, last: (k == N - 1)});
        end
    endtask

    task automatic wait_done(input int target);
        int budget = 2000;
        while (frames_done < target && budget > 0) begin
            @(negedge clk);
            #3;
            if (frames_done >= target) break;
            s_valid = ($urandom_range(1) == 1);
            s_data  = $urandom();
            budget--;
        end
        if (frames_done < target) begin
            tests++; fails++;
            $display("FAIL drain_timeout: frame %0d not completed", target);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"},  64'(s_ready),  64'(0));
        chk({tag, "_m_valid"},  64'(m_valid),  64'(0));
        chk({tag, "_m_last"},   64'(m_last),   64'(0));
        chk({tag, "_m_data"},   m_data,        64'(0));
        chk({tag, "_fft_sig"},  64'(fft_sig),  64'(0));
        chk({tag, "_fft_we"},   64'(fft_we),   64'(0));
        chk({tag, "_fft_rev"},  64'(fft_rev),  64'(0));
        chk({tag, "_fft_addr"}, 64'(fft_addr), 64'(0));
        chk({tag, "_fft_din"},  fft_din,       64'(0));
        chk({tag, "_fft_rst"},  64'(fft_rst),  64'(1));
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #3;
        chk({tag, "_rst_hold1"}, 64'(fft_rst), 64'(1));
        chk({tag, "_ready_hold"}, 64'(s_ready), 64'(0));
        @(negedge clk);
        #3;
        chk({tag, "_rst_clear"}, 64'(fft_rst), 64'(0));
        chk({tag, "_ready_up"}, 64'(s_ready), 64'(1));
    endtask

    initial begin
        int sc0;
        int budget;
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("por");
        release_reset("por");

        // Sparse input, heavily stalled output.
        r_duty = 30; full_rate = 0;
        load_frame(50, 0);
        wait_done(1);

        // Two frames back to back at full rate.
        r_duty = 100; full_rate = 1;
        load_frame(100, 0);
        wait_done(2);
        load_frame(100, 0);
        chk("back_to_back", 64'(first_acc_edge), 64'(last_pop_edge + 1));
        wait_done(3);

        // Abort a frame partway through the run window.
        r_duty = 60; full_rate = 0;
        sc0 = sig_count;
        load_frame(70, 0);
        budget = 500;
        while (sig_count == sc0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("sig_seen", 64'(sig_count), 64'(sc0 + 1));
        repeat (20) @(negedge clk);
        s_valid = 1'b0;
        #1 rst = 1'b0;
        #1 chk_reset_outputs("midrun");
        exp_q.delete();
        wr_q.delete();
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("midrun_held");
        release_reset("midrun");

        r_duty = 100; full_rate = 1;
        load_frame(100, 1);
        wait_done(4);
        @(negedge clk);
        #4;
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame controller wrapped around the in-place FFT core. Accepts a stream of real single-precision samples, writes one N-point frame into the core's memory in bit-reversed order, starts the transform and waits out its fixed run time. It then reads the N complex bins back in natural order and emits them as a back-pressured output stream. It owns every host-side port of the FFT core (write enable, reverse select, address, data, start pulse, core reset).

## Interface
Parameters:
- LOGN, 12, log2 of frame length N
- FW, 32, float word width (IEEE-754 single)
- CW, 64, complex word width = 2*FW; real part in [CW-1:FW], imaginary in [FW-1:0]
- RUN_CYCLES, 36872, clocks from start pulse until core results are readable; must cover LOGN*N/(2M)*6 plus margin
- TW, 16, width of run timer (2^TW > RUN_CYCLES)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts sample
- s_data  in  FW  real sample (float)
- m_valid  out  1  output bin valid
- m_ready  in  1  downstream accepts bin
- m_data  out  CW  complex bin
- m_last  out  1  marks bin N-1
- fft_rst  out  1  active-high reset to core
- fft_sig  out  1  start pulse to core
- fft_we  out  1  core write enable
- fft_rev  out  1  core bit-reverse address select
- fft_addr  out  LOGN  core address
- fft_din  out  CW  core write data
- fft_dout  in  CW  core read data, valid 1 clk after fft_addr

## Operation
- All outputs registered except s_ready (combinational from state).
- States: LOAD, START, RUN, DRAIN. Reset state LOAD, counters 0.
- LOAD: s_ready=1. On s_valid&s_ready: next clk fft_we=1, fft_rev=1, fft_addr=cnt, fft_din={s_data, FW'0}; cnt++. After accepting sample N-1: s_ready drops the following cycle, cnt wraps to 0, go START.
- START: one cycle; fft_sig=1 for exactly one clk, fft_we=0, timer cleared. → RUN.
- RUN: fft_sig=0, fft_we=0, s_ready=0; timer++ each clk; at timer==RUN_CYCLES-1 → DRAIN.
- DRAIN: fft_rev=0, fft_we=0. Read address rd_cnt 0..N-1 issued in order. 2-entry output FIFO; a read is issued only when (occupancy + reads in flight) < 2, so no bin is ever dropped under back-pressure. Returned fft_dout captured into FIFO 1 clk after issue. m_last=1 on the entry from address N-1. When that entry is popped (m_valid&m_ready): → LOAD, all counters 0.
- m_data/m_valid/m_last come from FIFO head; m_data holds steady while m_valid&~m_ready.
- fft_rst: held 1 while rst low and for 2 clks after rst deasserts (2-flop sync), then 0. Guarantees core leaves busy state after reset mid-RUN.
- s_data ignored when not handshaking; s_valid high outside LOAD has no effect.

## Timing
- Reset values: s_ready=0 while rst low, 1 once in LOAD after fft_rst clears (s_ready gated by fft_rst); m_valid=0, m_last=0, m_data=0, fft_sig=0, fft_we=0, fft_rev=0, fft_addr=0, fft_din=0, fft_rst=1.
- Write latency: handshake at clk k → core write at clk k+1.
- Start: fft_sig rises the cycle after last write cycle; no fft_we during fft_sig or RUN.
- Run: exactly RUN_CYCLES clks from fft_sig rise to first read issue.
- Read: first m_valid 2 clks after entering DRAIN (issue, capture). With m_ready held 1: one bin per clk, N bins in N consecutive clks.
- Frame-to-frame: LOAD re-entered the clk after last bin popped; s_ready=1 that clk.
- Reset asserted mid-operation: immediate async clear of all state and outputs; partial frame discarded.

## Test plan
- Impulse: frame s_data=1.0 at index 0, 0.0 elsewhere, m_ready=1 → N bins all 0x3F800000_00000000, m_last only on bin N-1.
- Write ordering: stream indices 0..N-1 → fft_we pulses N times, fft_rev=1, fft_addr=0..N-1, fft_din[FW-1:0]=0; one fft_sig pulse of width 1 follows, then RUN_CYCLES clks with fft_we=0.
- Back-pressure: m_ready random 30% duty → N bins in order, none lost or duplicated, m_data stable while stalled.
- Input gaps: s_valid random 50% duty → exactly N writes, fft_sig only after sample N-1, s_ready=0 during START/RUN/DRAIN.
- Reset mid-RUN: drop rst at timer=100 → all outputs to reset values, fft_rst high ≥2 clks after release, then clean frame (DC input 1.0 → bin0 real = N as float, others 0).
- Back-to-back frames: two frames, m_ready=1 → second frame's first sample accepted the clk after first frame's m_last handshake.
